// File: rtl/phys_pkg.sv
// rtl/phys_pkg.sv - shared state encoding and default motion constants for the player physics slice
package phys_pkg;

  // Player motion state; the collision and render blocks decode the same values.
  typedef enum logic [1:0] {
    GROUNDED  = 2'd0,
    RISING    = 2'd1,
    FALLING   = 2'd2,
    KNOCKBACK = 2'd3
  } phys_state_e;

  localparam int DEF_X_W      = 7;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_V_W      = 6;
  localparam int DEF_START_X  = 15;
  localparam int DEF_X_MIN    = 17;
  localparam int DEF_X_MAX    = 73;
  localparam int DEF_FLOOR_Y  = 48;
  localparam int DEF_CEIL_Y   = 19;
  localparam int DEF_STEP     = 2;
  localparam int DEF_JUMP_V   = 9;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_VMAX     = 15;
  localparam int DEF_KB_V     = 3;
  localparam int DEF_KB_TICKS = 4;

endpackage

// File: rtl/player_physics_if.sv
// rtl/player_physics_if.sv - control/opponent inputs and motion outputs of one player engine
interface player_physics_if
  import phys_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int V_W = DEF_V_W
);
  logic                  tick;
  logic                  move_left;
  logic                  move_right;
  logic                  jump;
  logic                  colliding;
  logic [X_W-1:0]        opp_x;
  logic [Y_W-1:0]        opp_y;
  logic                  hit;
  logic                  hit_dir;
  logic [X_W-1:0]        pos_x;
  logic [Y_W-1:0]        pos_y;
  logic signed [V_W-1:0] vel_y;
  logic                  airborne;
  logic                  landed;
  logic [1:0]            state;

  modport master (
    output tick, move_left, move_right, jump, colliding, opp_x, opp_y, hit, hit_dir,
    input  pos_x, pos_y, vel_y, airborne, landed, state
  );

  modport slave (
    input  tick, move_left, move_right, jump, colliding, opp_x, opp_y, hit, hit_dir,
    output pos_x, pos_y, vel_y, airborne, landed, state
  );
endinterface

// File: rtl/phys_vertical.sv
// rtl/phys_vertical.sv - vertical FSM: jump launch, gravity, floor/ceiling clamp, stomp and landing pulse
module phys_vertical
  import phys_pkg::*;
#(
  parameter int Y_W     = DEF_Y_W,
  parameter int V_W     = DEF_V_W,
  parameter int FLOOR_Y = DEF_FLOOR_Y,
  parameter int CEIL_Y  = DEF_CEIL_Y,
  parameter int JUMP_V  = DEF_JUMP_V,
  parameter int GRAVITY = DEF_GRAVITY,
  parameter int VMAX    = DEF_VMAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tick,
  input  logic                  i_jump_go,
  input  logic                  i_kb_active,
  input  logic                  i_kb_exit,
  input  logic                  i_colliding,
  input  logic [Y_W-1:0]        i_opp_y,
  output logic [Y_W-1:0]        o_pos_y,
  output logic signed [V_W-1:0] o_vel_y,
  output phys_state_e           o_state,
  output logic                  o_landed
);
  // Wide enough that pos_y + vel_y and vel_y + GRAVITY never wrap.
  localparam int S_W = ((Y_W > V_W) ? Y_W : V_W) + 2;
  localparam logic signed [S_W-1:0] C_FLOOR = S_W'(FLOOR_Y);
  localparam logic signed [S_W-1:0] C_CEIL  = S_W'(CEIL_Y);
  localparam logic signed [S_W-1:0] C_GRAV  = S_W'(GRAVITY);
  localparam logic signed [S_W-1:0] C_VMAX  = S_W'(VMAX);

  logic [Y_W-1:0]        r_pos_y;
  logic signed [V_W-1:0] r_vel_y;
  phys_state_e           r_state;
  logic                  r_landed;

  logic signed [S_W-1:0] w_y_sum, w_vel_sum, w_vel_cap;
  logic                  w_airborne, w_stomp, w_hit_floor, w_hit_ceil, w_land;
  logic [Y_W-1:0]        w_nx_y;
  logic signed [V_W-1:0] w_nx_v;
  phys_state_e           w_nx_s;

  // Next vertical position, velocity and state for the coming tick.
  always_comb begin
    w_y_sum     = $signed({{(S_W-Y_W){1'b0}}, r_pos_y}) + $signed({{(S_W-V_W){r_vel_y[V_W-1]}}, r_vel_y});
    w_vel_sum   = $signed({{(S_W-V_W){r_vel_y[V_W-1]}}, r_vel_y}) + C_GRAV;
    w_vel_cap   = (w_vel_sum > C_VMAX) ? C_VMAX : w_vel_sum;
    w_airborne  = (r_state != GROUNDED) || i_kb_active;
    w_stomp     = (r_state != GROUNDED) && i_colliding && (r_pos_y < i_opp_y);
    w_hit_floor = (w_y_sum >= C_FLOOR);
    // Ceiling only catches upward motion; at rest on the ceiling gravity must be allowed to pull down.
    w_hit_ceil  = (w_y_sum <= C_CEIL) && r_vel_y[V_W-1];
    w_nx_y      = r_pos_y;
    w_nx_v      = r_vel_y;
    w_nx_s      = r_state;
    w_land      = 1'b0;
    if (w_airborne) begin
      if (w_hit_floor) begin
        w_nx_y = Y_W'(FLOOR_Y);
        w_nx_v = '0;
        w_nx_s = GROUNDED;
        w_land = !i_kb_active;
      end else if (w_stomp) begin
        w_nx_y = (w_y_sum < C_CEIL) ? Y_W'(CEIL_Y) : w_y_sum[Y_W-1:0];
        w_nx_v = V_W'(GRAVITY);
        w_nx_s = FALLING;
      end else if (w_hit_ceil) begin
        w_nx_y = Y_W'(CEIL_Y);
        w_nx_v = '0;
        w_nx_s = FALLING;
      end else begin
        w_nx_y = w_y_sum[Y_W-1:0];
        w_nx_v = w_vel_cap[V_W-1:0];
        w_nx_s = w_vel_cap[S_W-1] ? RISING : FALLING;
      end
    end else if (i_jump_go) begin
      w_nx_y = Y_W'(FLOOR_Y - JUMP_V);
      w_nx_v = V_W'(GRAVITY - JUMP_V);
      w_nx_s = RISING;
    end
    // Knockback owns the state; vertical motion above still applies underneath it.
    if (i_kb_active) begin
      if (i_kb_exit) begin
        w_nx_s = (w_nx_y == Y_W'(FLOOR_Y)) ? GROUNDED : FALLING;
      end else begin
        w_nx_s = KNOCKBACK;
      end
    end
  end

  // Commit vertical state on tick; landed is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos_y  <= Y_W'(FLOOR_Y);
      r_vel_y  <= '0;
      r_state  <= GROUNDED;
      r_landed <= 1'b0;
    end else begin
      r_landed <= i_tick && w_land;
      if (i_tick) begin
        r_pos_y <= w_nx_y;
        r_vel_y <= w_nx_v;
        r_state <= w_nx_s;
      end
    end
  end

  assign o_pos_y  = r_pos_y;
  assign o_vel_y  = r_vel_y;
  assign o_state  = r_state;
  assign o_landed = r_landed;
endmodule

// File: rtl/player_physics.sv
// rtl/player_physics.sv - per-player motion engine top (horizontal path, hit latch, knockback); option PHYS_KNOCKBACK_EN
module player_physics
  import phys_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int V_W      = DEF_V_W,
  parameter int START_X  = DEF_START_X,
  parameter int X_MIN    = DEF_X_MIN,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int FLOOR_Y  = DEF_FLOOR_Y,
  parameter int CEIL_Y   = DEF_CEIL_Y,
  parameter int STEP     = DEF_STEP,
  parameter int JUMP_V   = DEF_JUMP_V,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int VMAX     = DEF_VMAX,
  parameter int KB_V     = DEF_KB_V,
  parameter int KB_TICKS = DEF_KB_TICKS
) (
  input logic             clk,
  input logic             reset,
  player_physics_if.slave bus
);
  localparam int XS_W = X_W + 2;
  localparam logic signed [XS_W-1:0] C_STEP = XS_W'(STEP);
  localparam logic signed [XS_W-1:0] C_KB_V = XS_W'(KB_V);
  localparam logic signed [XS_W-1:0] C_XMIN = XS_W'(X_MIN);
  localparam logic signed [XS_W-1:0] C_XMAX = XS_W'(X_MAX);

  logic [X_W-1:0]         r_pos_x, w_nx_x;
  logic signed [XS_W-1:0] w_dx, w_x_sum;
  logic                   w_blk_r, w_blk_l;
  logic                   w_kb_enter, w_kb_active, w_kb_exit, w_kb_dir, w_jump_go;
  phys_state_e            w_state;

`ifdef PHYS_KNOCKBACK_EN
  localparam int KC_W = $clog2(KB_TICKS + 1);
  logic            r_hit_pending, r_hit_dir;
  logic [KC_W-1:0] r_kb_cnt, w_kb_left;

  // A hit arriving on the tick cycle itself counts as pending; the counter includes the current tick.
  always_comb begin
    w_kb_enter  = r_hit_pending || bus.hit;
    w_kb_dir    = bus.hit ? bus.hit_dir : r_hit_dir;
    w_kb_active = w_kb_enter || (w_state == KNOCKBACK);
    w_kb_left   = (w_kb_enter ? KC_W'(KB_TICKS) : r_kb_cnt) - KC_W'(1);
    w_kb_exit   = (w_kb_left == '0);
  end

  // Sticky hit latch, consumed by the next tick, and the knockback tick counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_pending <= 1'b0;
      r_hit_dir     <= 1'b0;
      r_kb_cnt      <= '0;
    end else begin
      if (bus.hit) r_hit_dir <= bus.hit_dir;
      if (bus.tick) begin
        r_hit_pending <= 1'b0;
        if (w_kb_active) r_kb_cnt <= w_kb_left;
      end else if (bus.hit) begin
        r_hit_pending <= 1'b1;
      end
    end
  end
`else
  assign w_kb_enter  = 1'b0;
  assign w_kb_active = 1'b0;
  assign w_kb_exit   = 1'b0;
  assign w_kb_dir    = 1'b0;
`endif

  assign w_jump_go = bus.jump && (w_state == GROUNDED) && !w_kb_enter;

  // Horizontal step with collision blocking, clamped only on the side being moved toward.
  always_comb begin
    w_blk_r = bus.colliding && (bus.opp_x >= r_pos_x);
    w_blk_l = bus.colliding && (bus.opp_x <= r_pos_x);
    w_dx    = '0;
    if (w_kb_active) begin
      w_dx = w_kb_dir ? C_KB_V : -C_KB_V;
    end else if (bus.move_right && !bus.move_left && !w_blk_r) begin
      w_dx = C_STEP;
    end else if (bus.move_left && !bus.move_right && !w_blk_l) begin
      w_dx = -C_STEP;
    end
    w_x_sum = $signed({2'b00, r_pos_x}) + w_dx;
    w_nx_x  = w_x_sum[X_W-1:0];
    // An out-of-range start position is never dragged the opposite way by the clamp.
    if (w_dx[XS_W-1] && (w_x_sum < C_XMIN)) begin
      w_nx_x = (r_pos_x < X_W'(X_MIN)) ? r_pos_x : X_W'(X_MIN);
    end else if (!w_dx[XS_W-1] && (w_x_sum > C_XMAX)) begin
      w_nx_x = (r_pos_x > X_W'(X_MAX)) ? r_pos_x : X_W'(X_MAX);
    end
  end

  // Horizontal position register, updated only on tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos_x <= X_W'(START_X);
    end else if (bus.tick) begin
      r_pos_x <= w_nx_x;
    end
  end

  phys_vertical #(
    .Y_W(Y_W), .V_W(V_W), .FLOOR_Y(FLOOR_Y), .CEIL_Y(CEIL_Y),
    .JUMP_V(JUMP_V), .GRAVITY(GRAVITY), .VMAX(VMAX)
  ) u_vertical (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (bus.tick),
    .i_jump_go  (w_jump_go),
    .i_kb_active(w_kb_active),
    .i_kb_exit  (w_kb_exit),
    .i_colliding(bus.colliding),
    .i_opp_y    (bus.opp_y),
    .o_pos_y    (bus.pos_y),
    .o_vel_y    (bus.vel_y),
    .o_state    (w_state),
    .o_landed   (bus.landed)
  );

  assign bus.pos_x    = r_pos_x;
  assign bus.state    = w_state;
  assign bus.airborne = (w_state != GROUNDED);
endmodule

// File: tb/tb_player_physics.sv
// tb/tb_player_physics.sv - directed self-checking bench for player_physics
module tb_player_physics;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  player_physics_if #(.X_W(7), .Y_W(7), .V_W(6)) bus ();

  player_physics dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  initial begin
    int exp_y[13] = '{39, 31, 24, 19, 19, 20, 22, 25, 29, 34, 40, 47, 48};
    int exp_v[13] = '{-8, -7, -6, 0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
    int exp_s[13] = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.tick = 0; bus.move_left = 0; bus.move_right = 0; bus.jump = 0;
    bus.colliding = 0; bus.opp_x = '0; bus.opp_y = '0; bus.hit = 0; bus.hit_dir = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(bus.pos_x), 15);
    chk("rst_y", int'(bus.pos_y), 48);
    chk("rst_vel", int'($signed(bus.vel_y)), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_landed", int'(bus.landed), 0);
    chk("rst_airborne", int'(bus.airborne), 0);
    @(negedge clk);
    reset = 1'b1;

    repeat (10) step();
    chk("idle_x", int'(bus.pos_x), 15);
    chk("idle_y", int'(bus.pos_y), 48);
    chk("idle_state", int'(bus.state), 0);

    bus.move_left = 1; step();
    chk("left_below_min", int'(bus.pos_x), 15);
    bus.move_left = 0; bus.move_right = 1; step();
    chk("right_to_min", int'(bus.pos_x), 17);
    bus.move_right = 0; bus.move_left = 1; repeat (3) step();
    chk("left_at_min", int'(bus.pos_x), 17);
    bus.move_right = 1; repeat (2) step();
    chk("both_held", int'(bus.pos_x), 17);
    bus.move_left = 0; repeat (27) step();
    chk("right_run", int'(bus.pos_x), 71);
    step();
    chk("right_to_max", int'(bus.pos_x), 73);
    step();
    chk("right_at_max", int'(bus.pos_x), 73);
    bus.move_right = 0; bus.move_left = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_tick_ignored", int'(bus.pos_x), 73);
    repeat (21) step();
    chk("left_run", int'(bus.pos_x), 31);

    bus.move_left = 0; bus.colliding = 1; bus.opp_x = 40;
    bus.move_right = 1; step();
    chk("coll_right_block", int'(bus.pos_x), 31);
    bus.move_right = 0; bus.move_left = 1; step();
    chk("coll_left_free", int'(bus.pos_x), 29);
    bus.opp_x = 29; step();
    chk("coll_left_equal", int'(bus.pos_x), 29);
    bus.move_left = 0; bus.colliding = 0;

    bus.jump = 1;
    for (int i = 0; i < 13; i++) begin
      step();
      bus.jump = 0;
      chk($sformatf("jump_y%0d", i), int'(bus.pos_y), exp_y[i]);
      chk($sformatf("jump_v%0d", i), int'($signed(bus.vel_y)), exp_v[i]);
      chk($sformatf("jump_s%0d", i), int'(bus.state), exp_s[i]);
      chk($sformatf("jump_landed%0d", i), int'(bus.landed), (i == 12) ? 1 : 0);
      chk($sformatf("jump_air%0d", i), int'(bus.airborne), (i == 12) ? 0 : 1);
    end
    step();
    chk("landed_once", int'(bus.landed), 0);

    bus.jump = 1; step(); bus.jump = 0;
    chk("stomp_pre_y", int'(bus.pos_y), 39);
    bus.colliding = 1; bus.opp_y = 48; step();
    bus.colliding = 0;
    chk("stomp_y", int'(bus.pos_y), 31);
    chk("stomp_v", int'($signed(bus.vel_y)), 1);
    chk("stomp_s", int'(bus.state), 2);
    for (int i = 0; i < 20 && bus.state != 2'd0; i++) step();
    chk("stomp_land_s", int'(bus.state), 0);
    chk("stomp_land_y", int'(bus.pos_y), 48);

    bus.move_right = 1;
    @(negedge clk);
    bus.tick = 1;
    repeat (3) @(posedge clk);
    #1;
    bus.tick = 0;
    bus.move_right = 0;
    chk("tick_held_x", int'(bus.pos_x), 35);

`ifdef PHYS_KNOCKBACK_EN
    bus.move_left = 1; bus.jump = 1;
    @(negedge clk);
    bus.hit = 1; bus.hit_dir = 1;
    @(negedge clk);
    bus.hit = 0; bus.hit_dir = 0;
    step(); chk("kb_x0", int'(bus.pos_x), 38); chk("kb_s0", int'(bus.state), 3);
    step(); chk("kb_x1", int'(bus.pos_x), 41); chk("kb_s1", int'(bus.state), 3);
    step(); chk("kb_x2", int'(bus.pos_x), 44); chk("kb_s2", int'(bus.state), 3);
    bus.jump = 0;
    step(); chk("kb_x3", int'(bus.pos_x), 47); chk("kb_exit_s", int'(bus.state), 0);
    chk("kb_y", int'(bus.pos_y), 48);
    bus.move_left = 0;
`else
    @(negedge clk);
    bus.hit = 1; bus.hit_dir = 1;
    @(negedge clk);
    bus.hit = 0;
    repeat (4) step();
    chk("nokb_x", int'(bus.pos_x), 35);
    chk("nokb_s", int'(bus.state), 0);
`endif

    bus.jump = 1; step(); bus.jump = 0; step();
    chk("pre_reset_y", int'(bus.pos_y), 31);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_x", int'(bus.pos_x), 15);
    chk("async_rst_y", int'(bus.pos_y), 48);
    chk("async_rst_v", int'($signed(bus.vel_y)), 0);
    chk("async_rst_s", int'(bus.state), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst_x", int'(bus.pos_x), 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
